// File: rtl/iir_coeff_bank.sv
// Double-buffered a/b coefficient store for a direct form I IIR stage.
// Host writes go to the shadow bank; a commit swaps shadow into active on the next sample tick.
module iir_coeff_bank #(
    parameter int N           = 2,
    parameter int COEFF_WIDTH = 16,
    parameter int Q           = 14,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [COEFF_WIDTH-1:0]       rd_data,
    input  logic                         commit,
    input  logic                         abort,
    input  logic                         sample_tick,
    input  logic                         err_clr,
    output logic                         busy,
    output logic                         updated,
    output logic                         wr_err,
    output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
    output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs
);

    // state | meaning
    // IDLE  | shadow writable, no commit pending
    // ARMED | commit pending, swap on next sample_tick, shadow write-locked

    localparam int NW = 2*N + 1;
    localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1 << Q);

    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [COEFF_WIDTH-1:0] shadow_q [NW];
    logic [COEFF_WIDTH-1:0] active_q [NW];
    logic [COEFF_WIDTH-1:0] rd_data_q, rd_word;
    logic                   updated_q;
    logic                   wr_err_q;
    logic                   swap_en;
    logic                   wr_ok;
    logic                   wr_bad;
    logic                   addr_ok;

    // Pass-through filter: b[0] at unity, everything else zero.
    function automatic logic [COEFF_WIDTH-1:0] reset_word(input int idx);
        return (idx == N) ? UNITY : '0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (commit) state_d = ARMED;
            end
            ARMED: begin
                if (sample_tick)  state_d = IDLE;
                else if (abort)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ARMED);
        swap_en = (state_q == ARMED) && sample_tick;
        addr_ok = (int'(wr_addr) <= 2*N);
        wr_ok   = wr_en && (state_q == IDLE) && addr_ok;
        wr_bad  = wr_en && ((state_q == ARMED) || !addr_ok);
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NW; i++) begin
            if (int'(rd_addr) == i) rd_word = active_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                shadow_q[i] <= reset_word(i);
                active_q[i] <= reset_word(i);
            end
            updated_q <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (wr_ok && int'(wr_addr) == i) shadow_q[i] <= wr_data;
                if (swap_en) active_q[i] <= shadow_q[i];
            end
            updated_q <= swap_en;
            // A new illegal write outranks a simultaneous clear.
            wr_err_q  <= wr_bad | (wr_err_q & ~err_clr);
            rd_data_q <= rd_word;
        end
    end

    assign updated = updated_q;
    assign wr_err  = wr_err_q;
    assign rd_data = rd_data_q;

    for (genvar t = 0; t < N; t++) begin : g_pack_a
        assign packed_a_coeffs[COEFF_WIDTH*t +: COEFF_WIDTH] = active_q[t];
    end

    for (genvar t = 0; t <= N; t++) begin : g_pack_b
        assign packed_b_coeffs[COEFF_WIDTH*t +: COEFF_WIDTH] = active_q[N + t];
    end

endmodule
